pcie_read_mod: RTL
==================

Name: pcie_read_mod

Overview:
- Reverse-direction companion to the PCIe write path: the FPGA-simulated core pulls a 128-bit host response out of the shared PCIe block RAM.
- For a requesting thread it issues four 32-bit reads at RESP_BASE + (core_id<<2) + {0..3} and assembles the words into one 128-bit response.
- It checks the per-thread lead (sequence-toggle) bit to decide whether the host has written a new response since the last consumed one.
- It sits between the thread pipeline (request/response handshake) and the RAM read port; it shares RAM_busy arbitration with the write module.

Parameters:
- NTHREAD, 128, number of hardware threads; one lead bit is tracked per thread.
- ID_W, 7, width of core_id; 2^ID_W >= NTHREAD.
- RESP_BASE, 11'h200, word address of the response region (thread t occupies RESP_BASE+4t .. +4t+3).
- RD_LAT, 1, RAM read latency in cycles from an accepted rd_en to valid RAM_rdata (legal 1..3).
- POLL_GAP, 16, idle cycles between retries (used only with READ_RETRY_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  thread requests its response
- req_core_id  in  ID_W  requesting thread id
- req_ready  out  1  block can accept a request
- RAM_busy  in  1  RAM port owned by other agent; no read may issue this cycle
- RAM_rd_en  out  1  read strobe, registered
- RAM_addr  out  11  read word address, registered
- RAM_rdata  in  32  read data, valid RD_LAT cycles after an accepted strobe
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  128  assembled response
- rsp_core_id  out  ID_W  thread the response belongs to
- rsp_fresh  out  1  lead bit matched the expected value (new data)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - RAM_rd_en=0, RAM_addr=0, rsp_valid=0, rsp_data=0, rsp_core_id=0, rsp_fresh=0.
  - req_ready=0 while rst_n=0. State returns to IDLE.
  - All expected-lead bits reset to 1, so the host's first response per thread carries lead=1.
- FSM states: IDLE, ISSUE, DRAIN, RESP (plus WAIT with the optional feature).
- IDLE:
  - req_ready=1.
  - req_valid&&req_ready latches the id, clears the issue and receive counters, and moves to ISSUE.
- ISSUE:
  - Each cycle with RAM_busy=0: RAM_rd_en<=1, RAM_addr<=RESP_BASE+(id<<2)+issue_cnt, issue_cnt++.
  - A cycle with RAM_busy=1: RAM_rd_en<=0, address and count held. No request is lost or duplicated.
  - After the 4th issue, go to DRAIN.
- Receive side:
  - A shift register of depth RD_LAT tracks outstanding reads.
  - On each return, word k (receive order) is written to rsp_data[32k+31:32k].
  - RAM_busy does not affect returning data.
- DRAIN:
  - When the 4th word lands, compare rsp_data[127] with expected_lead[id].
  - rsp_fresh = (bit == expected).
  - Go to RESP with rsp_valid=1.
- RESP:
  - rsp_valid held, and rsp_data/rsp_core_id/rsp_fresh held stable, until rsp_ready.
  - On the handshake: if fresh, expected_lead[id] toggles. Stale leaves it unchanged. Return to IDLE.
  - rsp_ready is ignored when rsp_valid=0.
- Latency: minimum request-accept to rsp_valid = 4 + RD_LAT + 1 cycles (6 at RD_LAT=1). Each RAM_busy cycle adds one.
- Arithmetic: the address sum is 11 bits and wraps mod 2048. With default parameters it never wraps.
- req_valid asserted outside IDLE is ignored (req_ready=0). The id is sampled only at acceptance.
- Reset mid-operation: in-flight returns are discarded. No rsp_valid is produced for an aborted request. Lead state reinitialises.
- Only one request is in flight; there is no pipelining across requests.

Optional Feature:
- Macro: READ_RETRY_EN.
- Defined:
  - A stale result does not raise rsp_valid.
  - The FSM enters WAIT, counts POLL_GAP cycles, then re-enters ISSUE for the same id.
  - rsp_valid is raised only with rsp_fresh=1, so rsp_fresh is constant 1 at handshake.
  - Reset aborts WAIT.
- Undefined: stale responses are returned with rsp_fresh=0 as described in Behaviour. The WAIT state and POLL_GAP are unused.

Test Plan:
- Basic fresh read: RAM[0x208..0x20B]={11111111,22222222,33333333,C4444444}, request id=2, RD_LAT=1, RAM_busy=0 -> addresses 0x208,209,20A,20B on consecutive cycles; rsp_valid 6 cycles after accept; rsp_data=C4444444_33333333_22222222_11111111; rsp_fresh=1.
- Lead toggle: re-request id=2 with RAM unchanged -> rsp_fresh=0. Host rewrites word3=44444444 (bit31=0), request -> rsp_fresh=1. Expected lead for id 2 now 1 again.
- RAM_busy stall: assert RAM_busy for 3 cycles after the 2nd issue -> no rd_en during busy; the 3rd address is 0x20A (no skip or duplicate); rsp_valid delayed exactly 3 cycles; data correct.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_core_id stable; req_ready=0 throughout; req_valid pulses are ignored.
- Reset mid-read: drop rst_n after the 2nd issue -> next cycle RAM_rd_en=0, rsp_valid=0. A following request for id=2 with lead=1 data -> rsp_fresh=1.
- READ_RETRY_EN: stale data for id=5, POLL_GAP=16 -> no rsp_valid; re-issue at 0x214 after the gap. Host flips bit127 -> rsp_valid with rsp_fresh=1 on the next pass.

Source files
------------

// File: rtl/pcie_read_if.sv
// Thread-side request/response handshake and RAM read port for pcie_read_mod.
// master = the read module, slave = the thread pipeline plus RAM read port.
interface pcie_read_if #(
  parameter int unsigned ID_W = 7
);
  logic            req_valid;
  logic [ID_W-1:0] req_core_id;
  logic            req_ready;
  logic            RAM_busy;
  logic            RAM_rd_en;
  logic [10:0]     RAM_addr;
  logic [31:0]     RAM_rdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [127:0]    rsp_data;
  logic [ID_W-1:0] rsp_core_id;
  logic            rsp_fresh;

  modport master (
    input  req_valid, req_core_id, RAM_busy, RAM_rdata, rsp_ready,
    output req_ready, RAM_rd_en, RAM_addr, rsp_valid, rsp_data, rsp_core_id, rsp_fresh
  );

  modport slave (
    output req_valid, req_core_id, RAM_busy, RAM_rdata, rsp_ready,
    input  req_ready, RAM_rd_en, RAM_addr, rsp_valid, rsp_data, rsp_core_id, rsp_fresh
  );
endinterface

// File: rtl/pcie_read_mod.sv
// Pulls a 128-bit host response for one thread out of the shared PCIe RAM and
// flags it fresh/stale via a per-thread lead bit. Optional macro: READ_RETRY_EN.
//
// state | meaning
// IDLE  | ready for a thread request
// ISSUE | issuing the four word reads (stalls on RAM_busy)
// DRAIN | waiting for the remaining read data to return
// RESP  | response presented, waiting for rsp_ready
// WAIT  | (READ_RETRY_EN) stale result, pausing POLL_GAP cycles before re-reading
module pcie_read_mod #(
  parameter int unsigned NTHREAD   = 128,
  parameter int unsigned ID_W      = 7,
  parameter logic [10:0] RESP_BASE = 11'h200,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned POLL_GAP  = 16
) (
  input logic         i_clk,
  input logic         i_rst_n,
  pcie_read_if.master bus
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("pcie_read_mod: RD_LAT must be 1..3");
  end
  if ((2 ** ID_W) < NTHREAD) begin : g_bad_id_w
    $error("pcie_read_mod: ID_W too narrow for NTHREAD");
  end
  if (POLL_GAP < 1) begin : g_bad_poll_gap
    $error("pcie_read_mod: POLL_GAP must be at least 1");
  end

`ifdef READ_RETRY_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP, S_WAIT} state_t;
  localparam int unsigned WAIT_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  logic [WAIT_W-1:0] r_wait_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;
`endif

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rd_en;
  logic [10:0]        r_addr;
  logic [ID_W-1:0]    r_id;
  logic [1:0]         r_issue_cnt;
  logic [1:0]         r_rcv_cnt;
  logic [RD_LAT-1:0]  r_pend;
  logic               r_rsp_valid;
  logic [127:0]       r_rsp_data;
  logic [ID_W-1:0]    r_rsp_core_id;
  logic               r_rsp_fresh;
  logic [NTHREAD-1:0] r_exp_lead;

  logic [10:0] w_addr;
  logic        w_land;
  logic        w_match;
  logic        w_rcv_state;

  assign w_addr      = RESP_BASE + (11'(r_id) << 2) + 11'(r_issue_cnt);
  assign w_land      = r_pend[RD_LAT-1];
  // Bit 31 of the fourth word is rsp_data[127], the host's lead bit.
  assign w_match     = (bus.RAM_rdata[31] == r_exp_lead[r_id]);
  assign w_rcv_state = (r_state == S_ISSUE) || (r_state == S_DRAIN);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b0;
      r_rd_en       <= 1'b0;
      r_addr        <= '0;
      r_id          <= '0;
      r_issue_cnt   <= '0;
      r_rcv_cnt     <= '0;
      r_pend        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_core_id <= '0;
      r_rsp_fresh   <= 1'b0;
      r_exp_lead    <= '1;
`ifdef READ_RETRY_EN
      r_wait_cnt    <= '0;
`endif
    end else begin
      r_pend  <= RD_LAT'({r_pend, r_rd_en});
      r_rd_en <= 1'b0;

      if (w_land && w_rcv_state) begin
        r_rsp_data[{r_rcv_cnt, 5'd0} +: 32] <= bus.RAM_rdata;
        r_rcv_cnt <= r_rcv_cnt + 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_id        <= bus.req_core_id;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.RAM_busy) begin
            r_rd_en     <= 1'b1;
            r_addr      <= w_addr;
            r_issue_cnt <= r_issue_cnt + 2'd1;
            if (r_issue_cnt == 2'd3) r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (w_land && (r_rcv_cnt == 2'd3)) begin
`ifdef READ_RETRY_EN
            if (w_match) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_fresh   <= 1'b1;
              r_rsp_core_id <= r_id;
              r_state       <= S_RESP;
            end else begin
              r_wait_cnt <= WAIT_W'(POLL_GAP - 1);
              r_state    <= S_WAIT;
            end
`else
            r_rsp_valid   <= 1'b1;
            r_rsp_fresh   <= w_match;
            r_rsp_core_id <= r_id;
            r_state       <= S_RESP;
`endif
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_fresh) r_exp_lead[r_id] <= ~r_exp_lead[r_id];
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

`ifdef READ_RETRY_EN
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_state     <= S_ISSUE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.RAM_rd_en   = r_rd_en;
  assign bus.RAM_addr    = r_addr;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_core_id = r_rsp_core_id;
  assign bus.rsp_fresh   = r_rsp_fresh;

endmodule
